// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// muldiv_seq : multi-cycle RV32M mul/div sequencer (radix-2 shift-add, restoring)
// Optional MULDIV_RESULT_CACHE_EN: reuse the other half of the last result. Rev 1.0
// ============================================================================
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

   function automatic logic sgn_a(input logic [2:0] f);
      return f[2] ? ~f[0] : (f[1:0] != 2'b11);
   endfunction

   function automatic logic sgn_b(input logic [2:0] f);
      return f[2] ? ~f[0] : ~f[1];
   endfunction

   // High half = MULH*/remainder; low half = MUL/quotient.
   function automatic logic sel_hi(input logic [2:0] f);
      return f[2] ? f[1] : (f[1:0] != 2'b00);
   endfunction

   state_t              state, state_n;
   logic [2:0]          op;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic                neg_a, neg_b;
   logic [CW-1:0]       cnt;
   logic [2*XLEN-1:0]   acc;

   logic                accept, running, last, hit;
   logic                neg_a_in, neg_b_in, special;
   logic [XLEN-1:0]     a_in, b_in, sp_q, sp_r, cache_res;
   logic [XLEN:0]       mul_sum, div_rr, div_diff;
   logic [2*XLEN-1:0]   iter_next, prod_s;
   logic [XLEN-1:0]     fin_lo, fin_hi;

   always_comb begin
      accept   = (state == S_IDLE) & start & ~flush;
      running  = (state == S_MUL) | (state == S_DIV);
      last     = (cnt == CW'(XLEN-1));
      neg_a_in = sgn_a(funct3) & rs1[XLEN-1];
      neg_b_in = sgn_b(funct3) & rs2[XLEN-1];
      a_in     = neg_a_in ? -rs1 : rs1;
      b_in     = neg_b_in ? -rs2 : rs2;
      special  = funct3[2] & ((rs2 == '0) | (sgn_a(funct3) & (rs1 == MIN_NEG) & (rs2 == '1)));
      sp_q     = (rs2 == '0) ? '1 : rs1;
      sp_r     = (rs2 == '0) ? rs1 : '0;
   end

   // Multiply: multiplier in the low half shifts out LSB first while the
   // partial sum enters from the top. Divide: dividend shifts out MSB first
   // into the remainder half, quotient bits fill the low half.
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
      div_rr   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff = div_rr - {1'b0, b_mag};
      if (state == S_MUL)
         iter_next = {mul_sum, acc[XLEN-1:1]};
      else if (div_diff[XLEN])
         iter_next = {div_rr[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
         iter_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

      prod_s = (neg_a ^ neg_b) ? -iter_next : iter_next;
      if (state == S_MUL) begin
         fin_lo = prod_s[XLEN-1:0];
         fin_hi = prod_s[2*XLEN-1:XLEN];
      end else begin
         fin_lo = (neg_a ^ neg_b) ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
         fin_hi = neg_a ? -iter_next[2*XLEN-1:XLEN] : iter_next[2*XLEN-1:XLEN];
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (accept) begin
            if (hit || special) state_n = S_DONE;
            else if (funct3[2]) state_n = S_DIV;
            else                state_n = S_MUL;
         end
         S_MUL, S_DIV: if (last) state_n = S_DONE;
         default: state_n = S_IDLE;
      endcase
      if (flush) state_n = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op     <= '0;
         a_mag  <= '0;
         b_mag  <= '0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         result <= '0;
      end else if (accept) begin
         op    <= funct3;
         a_mag <= a_in;
         b_mag <= b_in;
         neg_a <= neg_a_in;
         neg_b <= neg_b_in;
         cnt   <= '0;
         acc   <= {{XLEN{1'b0}}, (funct3[2] ? a_in : b_in)};
         if (hit)          result <= cache_res;
         else if (special) result <= funct3[1] ? sp_r : sp_q;
      end else if (running && !flush) begin
         acc <= iter_next;
         cnt <= cnt + CW'(1);
         if (last) result <= sel_hi(op) ? fin_hi : fin_lo;
      end
   end

`ifdef MULDIV_RESULT_CACHE_EN
   logic            cache_valid;
   logic [2:0]      cache_op;
   logic [XLEN-1:0] cache_rs1, cache_rs2, cache_lo, cache_hi;

   // MUL low bits do not depend on signedness, so any cached product serves it.
   always_comb begin
      hit = cache_valid & (rs1 == cache_rs1) & (rs2 == cache_rs2)
          & (funct3[2] == cache_op[2]) & (funct3 != cache_op)
          & ((funct3 == 3'b000) | ((sgn_a(funct3) == sgn_a(cache_op)) &
                                   (sgn_b(funct3) == sgn_b(cache_op))));
      cache_res = sel_hi(funct3) ? cache_hi : cache_lo;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid <= 1'b0;
         cache_op    <= '0;
         cache_rs1   <= '0;
         cache_rs2   <= '0;
         cache_lo    <= '0;
         cache_hi    <= '0;
      end else if (flush) begin
         cache_valid <= 1'b0;
      end else if (accept && hit) begin
         cache_op <= funct3;
      end else if (accept && special) begin
         cache_valid <= 1'b1;
         cache_op    <= funct3;
         cache_rs1   <= rs1;
         cache_rs2   <= rs2;
         cache_lo    <= sp_q;
         cache_hi    <= sp_r;
      end else if (running && last) begin
         cache_valid <= 1'b1;
         cache_op    <= op;
         cache_rs1   <= neg_a ? -a_mag : a_mag;
         cache_rs2   <= neg_b ? -b_mag : b_mag;
         cache_lo    <= fin_lo;
         cache_hi    <= fin_hi;
      end
   end
`else
   assign hit       = 1'b0;
   assign cache_res = '0;
`endif

   assign busy  = (state != S_IDLE);
   assign done  = (state == S_DONE);
   assign stall = accept | running;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// tb_muldiv_seq : directed self-checking bench for muldiv_seq (XLEN=32).
module tb_muldiv_seq;

   localparam int XLEN = 32;
`ifdef MULDIV_RESULT_CACHE_EN
   localparam int HIT_LAT = 1;
`else
   localparam int HIT_LAT = 33;
`endif

   logic            clk = 1'b0;
   logic            rst_n, start, flush;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1, rs2;
   logic            stall, busy, done;
   logic [XLEN-1:0] result;

   int errors = 0;
   int checks = 0;

   muldiv_seq #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .funct3 (funct3),
      .rs1    (rs1),
      .rs2    (rs2),
      .flush  (flush),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int n;
      int stall_bad;
      @(negedge clk);
      funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
      #1 check({tag, "/stall_c0"}, stall, 1);
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      stall_bad = 0;
      do begin
         @(negedge clk);
         n++;
         if (!done && !stall) stall_bad++;
      end while (!done && n < 200);
      check({tag, "/latency"}, n, exp_lat);
      check({tag, "/result"}, result, exp_res);
      check({tag, "/stall_done"}, stall, 0);
      check({tag, "/stall_busy"}, stall_bad, 0);
      @(negedge clk);
      check({tag, "/idle_after"}, {done, busy}, 0);
   endtask

   initial begin
      int n;
      int seen;
      logic [31:0] prior;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
      repeat (2) @(negedge clk);
      check("reset/busy", busy, 0);
      check("reset/done", done, 0);
      check("reset/result", result, 0);
      check("reset/stall", stall, 0);
      rst_n = 1'b1;

      run_op("mul_7_m3",   3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33);
      run_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
      run_op("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 33);
      run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
      run_op("divu_by0",   3'b101, 32'h0000_1234, 32'd0,        32'hFFFF_FFFF, 1);
      run_op("rem_by0",    3'b110, 32'h0000_1234, 32'd0,        32'h0000_1234, 1);
      run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

      // Result reuse: second op of a matching pair completes early when cached.
      run_op("div_100_7",  3'b100, 32'd100, 32'd7, 32'd14, 33);
      run_op("rem_100_7",  3'b110, 32'd100, 32'd7, 32'd2,  HIT_LAT);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      run_op("rem_after_flush", 3'b110, 32'd100, 32'd7, 32'd2, 33);

      // Start pulsed mid-multiply must be ignored.
      @(negedge clk);
      funct3 = 3'b000; rs1 = 32'd123; rs2 = 32'd456; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 5) begin
            funct3 = 3'b101; rs1 = 32'hFFFF; rs2 = 32'd0; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
         end
      end while (!done && n < 200);
      check("ign_start/latency", n, 33);
      check("ign_start/result", result, 32'h0000_DB18);
      @(negedge clk);
      check("ign_start/idle_after", busy, 0);

      // Flush in cycle 10 of a DIVU: back to IDLE, no done, result held.
      prior = result;
      @(negedge clk);
      funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("flush/idle_c11", busy, 0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("flush/no_done", seen, 0);
      check("flush/result_held", result, prior);

      // Asynchronous reset mid-operation.
      @(negedge clk);
      funct3 = 3'b000; rs1 = 32'h10; rs2 = 32'h10; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("areset/busy", busy, 0);
      check("areset/result", result, 0);
      @(negedge clk); rst_n = 1'b1;
      run_op("mul_after_rst", 3'b000, 32'h10, 32'h10, 32'h100, 33);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations that the single-cycle ALU cannot perform.
- Sits beside the ALU in the execute stage and is started by the decode-generated M-extension ALUOp path.
- Runs a radix-2 shift-add multiplier or a restoring divider over XLEN iterations.
- Holds the pipeline via stall and returns one result with a done pulse.

Parameters:
- XLEN, 32, operand/result width; must be even and at least 8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when state is IDLE
- funct3  in  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  XLEN  operand A / dividend
- rs2  in  XLEN  operand B / divisor
- flush  in  1  synchronous abort from branch/trap
- stall  out  1  hold the pipeline front-end
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse; result valid
- result  out  XLEN  final value, held until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, result=0, all internal registers 0.
- States and transitions:
  - IDLE -> MUL on accepted start with funct3[2]=0.
  - IDLE -> DIV on accepted start with funct3[2]=1 and no special case.
  - IDLE -> DONE on accepted start that hits a division special case.
  - MUL/DIV -> DONE when the iteration counter reaches XLEN-1.
  - DONE -> IDLE always.
- Accepted start: start=1 and flush=0 in IDLE. On acceptance, latch funct3, latch operand magnitudes and sign flags, and clear the counter.
- start in MUL, DIV or DONE is ignored. There is no queueing; the pipeline holds start until done.
- stall is combinational: (IDLE & start & !flush) | MUL | DIV. It is low in DONE so the instruction retires in the done cycle.
- Latency for normal ops: start accepted in cycle 0, iterations in cycles 1..XLEN, done=1 in cycle XLEN+1.
- Latency for special cases: done=1 in cycle 1.
- Signedness:
  - rs1 is signed for MUL, MULH, MULHSU, DIV, REM.
  - rs2 is signed for MUL, MULH, DIV, REM.
  - Negative operands are converted to two's-complement magnitude.
- Multiply: 2*XLEN-bit unsigned accumulate of one multiplier bit per cycle. Negate the product if the sign flags differ.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle, MSB first.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Division special cases, decided at start:
  - rs2=0: quotient all ones, remainder = rs1.
  - Signed overflow, DIV/REM with rs1 = 1 followed by XLEN-1 zeros and rs2 all ones: quotient = rs1, remainder = 0.
- result updates only in the cycle that transitions into DONE; it is otherwise stable.
- flush=1 in any state: next state IDLE, no done, result unchanged. flush wins over start in the same cycle.
- Reset mid-operation: immediate return to reset values.
- Arithmetic wraps modulo 2^XLEN; nothing saturates.

Optional Feature:
- Macro MULDIV_RESULT_CACHE_EN.
- Defined:
  - Keep the last completed rs1, rs2 and signedness class, plus both halves of the product or both quotient and remainder.
  - A start whose operands and class match, and whose op selects the other half (e.g. DIV then REM, MULHU then MUL), goes IDLE -> DONE with done in cycle 1.
  - Cache is invalidated by reset or flush.
- Undefined: every op takes full latency; no cache storage is instantiated.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> done in cycle 33, result 0xFFFFFFEB; stall high cycles 0..32, low in cycle 33.
- MULHU rs1=rs2=0xFFFFFFFF -> result 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=2 -> result 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> result 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF.
- Special cases, each with done in cycle 1:
  - DIVU rs1=0x1234, rs2=0 -> 0xFFFFFFFF.
  - REM rs1=0x1234, rs2=0 -> 0x1234.
  - DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000.
- Flush and ignored start: start DIVU, flush asserted in cycle 10 -> IDLE in cycle 11, no done pulse, result keeps its prior value. A start pulsed in cycle 5 of a MUL is ignored and the original result is correct.
- With MULDIV_RESULT_CACHE_EN: DIV 100/7 (result 14, cycle 33), then REM 100/7 -> result 2 in cycle 1. After a flush, the same REM takes 33 cycles.
